// File: rtl/mem_copier_chunked_dma.sv
// Chunked DMA memory copier: reads up to BUF_DEPTH words into a local buffer, then writes them out.
// Optional running checksum of read words is enabled by defining MEM_COPIER_CHECKSUM_EN.
module mem_copier_chunked_dma #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned BUF_DEPTH = 128,
   parameter logic [2:0]  SIZE_CODE = 3'b011
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              conf_done,
   input  logic [31:0]       conf_info_len,
   input  logic [31:0]       conf_info_src_offset,
   input  logic [31:0]       conf_info_dst_offset,
   output logic              acc_done,
   output logic [31:0]       debug,
   output logic [31:0]       checksum,
   input  logic              dma_read_ctrl_ready,
   output logic              dma_read_ctrl_valid,
   output logic [31:0]       dma_read_ctrl_data_index,
   output logic [31:0]       dma_read_ctrl_data_length,
   output logic [2:0]        dma_read_ctrl_data_size,
   output logic [5:0]        dma_read_ctrl_data_user,
   input  logic              dma_read_chnl_valid,
   output logic              dma_read_chnl_ready,
   input  logic [DATA_W-1:0] dma_read_chnl_data,
   input  logic              dma_write_ctrl_ready,
   output logic              dma_write_ctrl_valid,
   output logic [31:0]       dma_write_ctrl_data_index,
   output logic [31:0]       dma_write_ctrl_data_length,
   output logic [2:0]        dma_write_ctrl_data_size,
   output logic [5:0]        dma_write_ctrl_data_user,
   input  logic              dma_write_chnl_ready,
   output logic              dma_write_chnl_valid,
   output logic [DATA_W-1:0] dma_write_chnl_data
);

   localparam int unsigned AW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_PREF = 3'd4,
      WR_DATA = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t state, state_nxt;

   logic [31:0]       len_q, src_q, dst_q, done_words;
   logic [CW-1:0]     chunk_len, rd_cnt, wr_cnt;
   logic [15:0]       chunk_cnt;
   logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
   logic [DATA_W-1:0] out_data;

   logic              start, rd_hs, wr_hs, wr_last;
   logic [31:0]       done_next, remaining;
   logic [CW-1:0]     chunk_next, wr_cnt_inc;

   assign start      = (state == IDLE) && conf_done;
   assign rd_hs      = dma_read_chnl_valid && dma_read_chnl_ready;
   assign wr_hs      = (state == WR_DATA) && dma_write_chnl_ready;
   assign wr_last    = (wr_cnt == chunk_len - CW'(1));
   assign done_next  = done_words + 32'(chunk_len);
   assign wr_cnt_inc = wr_cnt + CW'(1);

   // Words left to copy as seen when the next chunk is about to be requested.
   assign remaining  = (state == IDLE) ? conf_info_len : len_q - done_next;
   assign chunk_next = (remaining < 32'(BUF_DEPTH)) ? remaining[CW-1:0] : CW'(BUF_DEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt            = state;
      acc_done             = 1'b0;
      dma_read_ctrl_valid  = 1'b0;
      dma_read_chnl_ready  = 1'b0;
      dma_write_ctrl_valid = 1'b0;
      dma_write_chnl_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (conf_done) state_nxt = (conf_info_len == 32'd0) ? DONE : RD_REQ;
         end
         RD_REQ: begin
            dma_read_ctrl_valid = 1'b1;
            if (dma_read_ctrl_ready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            dma_read_chnl_ready = (rd_cnt != chunk_len);
            if (rd_cnt == chunk_len) state_nxt = WR_REQ;
         end
         WR_REQ: begin
            dma_write_ctrl_valid = 1'b1;
            if (dma_write_ctrl_ready) state_nxt = WR_PREF;
         end
         WR_PREF: state_nxt = WR_DATA;
         WR_DATA: begin
            dma_write_chnl_valid = 1'b1;
            if (dma_write_chnl_ready && wr_last) state_nxt = (done_next == len_q) ? DONE : RD_REQ;
         end
         DONE: begin
            acc_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         done_words <= '0;
         chunk_cnt  <= '0;
         chunk_len  <= '0;
         rd_cnt     <= '0;
         wr_cnt     <= '0;
         out_data   <= '0;
      end else begin
         if (start) begin
            len_q      <= conf_info_len;
            src_q      <= conf_info_src_offset;
            dst_q      <= conf_info_dst_offset;
            done_words <= '0;
            chunk_cnt  <= '0;
         end
         if (rd_hs) rd_cnt <= rd_cnt + CW'(1);
         if (wr_hs) begin
            wr_cnt <= wr_cnt_inc;
            if (wr_last) begin
               done_words <= done_next;
               chunk_cnt  <= chunk_cnt + 16'd1;
            end
         end
         // Chunk entry must win over the last write handshake of the previous chunk.
         if (state_nxt == RD_REQ && state != RD_REQ) begin
            chunk_len <= chunk_next;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
         end
         // Registered buffer read doubles as the output skid: it only advances on a handshake.
         if (state == WR_PREF)  out_data <= buf_mem[0];
         else if (wr_hs)        out_data <= buf_mem[wr_cnt_inc[AW-1:0]];
      end
   end

   // NOTE: the buffer array is deliberately left without reset so it maps onto RAM;
   // every word is written in the read phase before the write phase can read it.
   always_ff @(posedge clk) begin
      if (rd_hs) buf_mem[rd_cnt[AW-1:0]] <= dma_read_chnl_data;
   end

`ifdef MEM_COPIER_CHECKSUM_EN
   logic [31:0] sum_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       sum_q <= '0;
      else if (start) sum_q <= '0;
      else if (rd_hs) sum_q <= sum_q + dma_read_chnl_data[31:0];
   end
   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

   assign debug                      = {chunk_cnt, 13'd0, state};
   assign dma_read_ctrl_data_index   = src_q + done_words;
   assign dma_read_ctrl_data_length  = 32'(chunk_len);
   assign dma_read_ctrl_data_size    = SIZE_CODE;
   assign dma_read_ctrl_data_user    = 6'd0;
   assign dma_write_ctrl_data_index  = dst_q + done_words;
   assign dma_write_ctrl_data_length = 32'(chunk_len);
   assign dma_write_ctrl_data_size   = SIZE_CODE;
   assign dma_write_ctrl_data_user   = 6'd0;
   assign dma_write_chnl_data        = out_data;

endmodule
